// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and register-index width for the pipeline controller
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between the ID and EX stages
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller; HAZARD_PERF_EN adds stall and flush counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 256,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 timeout_o,
    output logic [1:0]           state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          stall_cycles_o,
    output logic [31:0]          flush_count_o
`endif
);

    // One extra bit so WAIT_MAX = 2**CNT_W is still representable
    localparam logic [CNT_W:0] WAIT_LIM = (CNT_W + 1)'(WAIT_MAX);
    localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

    state_t         state;
    logic [CNT_W:0] wait_cnt;
    logic           redirect_pend;
    logic           load_use;
    logic           redirect;
    logic           decode;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        redirect    = ex_redirect;
        decode      = 1'b0;

        case (state)
            ST_RUN:      decode = !(mem_req && !mem_ready);
            // A redirect seen while frozen must still be honoured on the release cycle
            ST_MEM_WAIT: begin
                decode   = mem_ready;
                redirect = ex_redirect || redirect_pend;
            end
            default:     decode = 1'b0;
        endcase

        if (decode && reset) begin
            if (redirect) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_RUN;
            wait_cnt      <= '0;
            redirect_pend <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state         <= ST_MEM_WAIT;
                        wait_cnt      <= CNT_ONE;
                        redirect_pend <= ex_redirect;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state         <= ST_RUN;
                        wait_cnt      <= '0;
                        redirect_pend <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                        if (wait_cnt == WAIT_LIM) begin
                            state     <= ST_TIMEOUT;
                            timeout_o <= 1'b1;
                        end
                    end
                end
                ST_TIMEOUT: timeout_o <= 1'b1;
                default: begin
                    state         <= ST_RUN;
                    wait_cnt      <= '0;
                    redirect_pend <= 1'b0;
                    timeout_o     <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (if_id_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 8;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, timeout_o;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_o, flush_count_o;
`endif

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .timeout_o   (timeout_o),
        .state_o     (state_o)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Model: waiting on memory, consecutive frozen cycles of the current access, pending redirect, stuck
    bit      m_wait;
    int      m_frozen;
    bit      m_pend;
    bit      m_stuck;
    longint  m_stalls;
    longint  m_flushes;

    logic [8:0] obs, expv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] model_out();
        logic [5:0] ctl;
        logic [1:0] st;
        bit frozen, redir, lu;
        if (!reset) return 9'd0;
        if (m_stuck) return {6'b0, 1'b1, 2'd2};
        st     = m_wait ? 2'd1 : 2'd0;
        frozen = m_wait ? !mem_ready : (mem_req && !mem_ready);
        if (frozen) return {6'b0, 1'b0, st};
        redir = ex_redirect || (m_wait && m_pend);
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (redir)   ctl = 6'b111111;
        else if (lu) ctl = 6'b001101;
        else         ctl = 6'b111100;
        return {ctl, 1'b0, st};
    endfunction

    function automatic logic [8:0] observed();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, timeout_o, state_o};
    endfunction

    task automatic model_clear();
        m_wait = 0; m_frozen = 0; m_pend = 0; m_stuck = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_tick();
        logic [8:0] o;
        o = model_out();
        if (!o[8] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        if (o[4] && m_flushes < 64'hFFFF_FFFF) m_flushes++;
        if (m_stuck) return;
        if (m_wait) begin
            if (mem_ready) begin
                m_wait = 0; m_frozen = 0; m_pend = 0;
            end else begin
                m_frozen++;
                if (m_frozen == WAIT_MAX + 1) m_stuck = 1;
            end
        end else if (mem_req && !mem_ready) begin
            m_wait = 1; m_frozen = 1; m_pend = ex_redirect;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        if (reset) model_tick();
        else model_clear();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; ex_redirect = 0; mem_req = 0; mem_ready = 1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_req = 1; mem_ready = 0; ex_redirect = 1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        total++;
        if (observed() !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", observed(), 9'd0);
        end
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        expv = model_out(); total++;
        if (observed() !== expv) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", observed(), expv);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        @(negedge clk);
        expv = model_out(); total++;
        if (observed() !== expv || {pc_en, if_id_en, id_ex_flush} !== 3'b001) begin
            bad++;
            $display("FAIL load_use_bubble got=%b want=%b", observed(), expv);
        end
        next_cycle();
        ex_mem_read = 0; ex_rd = 0;
        @(negedge clk);
        total++;
        if (observed() !== 9'b111100_0_00) begin
            bad++;
            $display("FAIL load_use_resume got=%b want=%b", observed(), 9'b111100_0_00);
        end
        next_cycle();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
        @(negedge clk);
        expv = model_out(); total++;
        if (observed() !== expv) begin
            bad++;
            $display("FAIL load_x0_no_stall got=%b want=%b", observed(), expv);
        end
        next_cycle();
    endtask

    task automatic test_redirect_over_lu();
        idle_inputs();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1; ex_redirect = 1;
        @(negedge clk);
        total++;
        if (observed() !== 9'b111111_0_00) begin
            bad++;
            $display("FAIL redirect_over_lu got=%b want=%b", observed(), 9'b111111_0_00);
        end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        int frozen_cnt;
        frozen_cnt = 0;
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            mem_req = 1;
            mem_ready = (c == 3);
            ex_redirect = (c == 0);
            @(negedge clk);
            expv = model_out(); total++;
            if (observed() !== expv) begin
                bad++;
                $display("FAIL mem_wait_cycle%0d got=%b want=%b", c, observed(), expv);
            end
            if (!pc_en) frozen_cnt++;
            if (c == 3) begin
                total++;
                if ({if_id_flush, id_ex_flush, state_o} !== 4'b11_01) begin
                    bad++;
                    $display("FAIL mem_wait_release_flush got=%b want=%b",
                             {if_id_flush, id_ex_flush, state_o}, 4'b1101);
                end
            end
            next_cycle();
        end
        total++;
        if (frozen_cnt !== 3) begin
            bad++;
            $display("FAIL mem_wait_stall_len got=%0d want=3", frozen_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int wait_cycles;
        wait_cycles = 0;
        idle_inputs();
        mem_req = 1; mem_ready = 0;
        for (int c = 0; c < WAIT_MAX + 5; c++) begin
            @(negedge clk);
            expv = model_out(); total++;
            if (observed() !== expv) begin
                bad++;
                $display("FAIL timeout_cycle%0d got=%b want=%b", c, observed(), expv);
            end
            if (state_o == 2'd1) wait_cycles++;
            if (c >= WAIT_MAX + 1) mem_ready = 1;
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (wait_cycles !== WAIT_MAX || {timeout_o, state_o, pc_en} !== 4'b1_10_0) begin
            bad++;
            $display("FAIL timeout_sticky got=%0d/%b want=%0d/%b",
                     wait_cycles, {timeout_o, state_o, pc_en}, WAIT_MAX, 4'b1100);
        end
        do_reset();
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        mem_req = 1; mem_ready = 0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        total++;
        if (observed() !== 9'd0) begin
            bad++;
            $display("FAIL reset_mid_wait got=%b want=%b", observed(), 9'd0);
        end
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++;
        if (observed() !== 9'b111100_0_00) begin
            bad++;
            $display("FAIL reset_mid_wait_resume got=%b want=%b", observed(), 9'b111100_0_00);
        end
        next_cycle();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_redirect = ($urandom_range(0, 4) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b0;
                model_clear();
            end else begin
                reset = 1'b1;
            end
            @(negedge clk);
            expv = model_out(); total++;
            if (observed() !== expv) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL random_cycle%0d got=%b want=%b", c, observed(), expv);
            end
            next_cycle();
        end
        reset = 1'b1;
        idle_inputs();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        total++;
        if (stall_cycles_o !== 32'(m_stalls) || flush_count_o !== 32'(m_flushes)) begin
            bad++;
            $display("FAIL perf_totals got=%0d/%0d want=%0d/%0d",
                     stall_cycles_o, flush_count_o, m_stalls, m_flushes);
        end
        force dut.stall_q = 32'hFFFF_FFFF;
        force dut.flush_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.stall_q;
        release dut.flush_q;
        mem_req = 1; mem_ready = 0; ex_redirect = 1;
        next_cycle();
        ex_redirect = 1; mem_ready = 1;
        next_cycle();
        @(negedge clk);
        total++;
        if (stall_cycles_o !== 32'hFFFF_FFFF || flush_count_o !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL perf_saturate got=%h/%h want=ffffffff/ffffffff",
                     stall_cycles_o, flush_count_o);
        end
        do_reset();
        idle_inputs();
        @(negedge clk);
        total++;
        if (stall_cycles_o !== 32'd0 || flush_count_o !== 32'd0) begin
            bad++;
            $display("FAIL perf_reset got=%0d/%0d want=0/0", stall_cycles_o, flush_count_o);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_clear();
        test_reset();
        test_load_use();
        test_redirect_over_lu();
        test_mem_wait();
        test_reset_mid_wait();
        test_timeout();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
